hazard_stall_unit: RTL and testbench

HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

---
 rtl/hazard_stall_unit.sv | 89 ++++++++
 tb/tb_hazard_stall_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_unit.sv
// Hazard detection and stall control for a 5-stage pipeline with branches resolved in ID.
// Optional saturating stall-cycle counter is built only when HAZARD_STATS_EN is defined.
module hazard_stall_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic       ID_EX_MemRead,
    input  logic       ID_EX_RegWrite,
    input  logic [4:0] ID_EX_RegisterRd,
    input  logic       EX_MEM_MemRead,
    input  logic [4:0] EX_MEM_RegisterRd,
    input  logic [4:0] IF_ID_RegisterRs,
    input  logic [4:0] IF_ID_RegisterRt,
    input  logic       IF_ID_UsesRt,
    input  logic       IF_ID_Branch,
    input  logic       branch_taken,
    input  logic       jump,
    output logic       PC_write,
    output logic       IF_ID_write,
    output logic       ID_EX_bubble,
    output logic       IF_ID_flush
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0] stall_count
`endif
);

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t r_state;

    logic w_matchEx;
    logic w_matchMem;
    logic w_hLu;
    logic w_hBa;
    logic w_hBl2;
    logic w_hBl1;
    logic w_stall;

    // Register 0 is hard-wired, so it can never be a real producer.
    assign w_matchEx  = (ID_EX_RegisterRd != 5'd0) &&
                        ((ID_EX_RegisterRd == IF_ID_RegisterRs) ||
                         (IF_ID_UsesRt && (ID_EX_RegisterRd == IF_ID_RegisterRt)));
    assign w_matchMem = (EX_MEM_RegisterRd != 5'd0) &&
                        ((EX_MEM_RegisterRd == IF_ID_RegisterRs) ||
                         (IF_ID_UsesRt && (EX_MEM_RegisterRd == IF_ID_RegisterRt)));

    assign w_hLu  = ID_EX_MemRead && w_matchEx;
    assign w_hBa  = IF_ID_Branch && ID_EX_RegWrite && !ID_EX_MemRead && w_matchEx;
    assign w_hBl2 = IF_ID_Branch && ID_EX_MemRead && w_matchEx;
    assign w_hBl1 = IF_ID_Branch && EX_MEM_MemRead && w_matchMem;

    // Reset forces the pipeline to free-run; HOLD covers the second cycle of a load-branch stall.
    assign w_stall = !rst && ((r_state == HOLD) || w_hLu || w_hBa || w_hBl2 || w_hBl1);

    assign PC_write     = !w_stall;
    assign IF_ID_write  = !w_stall;
    assign ID_EX_bubble = w_stall;
    assign IF_ID_flush  = !rst && !w_stall && (jump || (IF_ID_Branch && branch_taken));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
        end else if (r_state == HOLD) begin
            r_state <= RUN;
        end else if (w_hBl2) begin
            r_state <= HOLD;
        end else begin
            r_state <= RUN;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [15:0] r_stallCount;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stallCount <= 16'd0;
        end else if (w_stall && (r_stallCount != 16'hFFFF)) begin
            r_stallCount <= r_stallCount + 16'd1;
        end
    end

    assign stall_count = r_stallCount;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit: directed pipeline scenarios plus random traffic
// compared against a cycle-count reference model. Counter checks compile under HAZARD_STATS_EN.
module tb_hazard_stall_unit;

    logic       clk;
    logic       rst;
    logic       ID_EX_MemRead;
    logic       ID_EX_RegWrite;
    logic [4:0] ID_EX_RegisterRd;
    logic       EX_MEM_MemRead;
    logic [4:0] EX_MEM_RegisterRd;
    logic [4:0] IF_ID_RegisterRs;
    logic [4:0] IF_ID_RegisterRt;
    logic       IF_ID_UsesRt;
    logic       IF_ID_Branch;
    logic       branch_taken;
    logic       jump;
    logic       PC_write;
    logic       IF_ID_write;
    logic       ID_EX_bubble;
    logic       IF_ID_flush;
`ifdef HAZARD_STATS_EN
    logic [15:0] stall_count;
`endif

    int assertCount = 0;
    int failCount   = 0;

    // Reference model: number of extra stall cycles still owed, and the expected counter value.
    int holdLeft   = 0;
    int modelCount = 0;
    bit countKnown = 0;
    bit expStall;

    hazard_stall_unit dut (
        .clk               (clk),
        .rst               (rst),
        .ID_EX_MemRead     (ID_EX_MemRead),
        .ID_EX_RegWrite    (ID_EX_RegWrite),
        .ID_EX_RegisterRd  (ID_EX_RegisterRd),
        .EX_MEM_MemRead    (EX_MEM_MemRead),
        .EX_MEM_RegisterRd (EX_MEM_RegisterRd),
        .IF_ID_RegisterRs  (IF_ID_RegisterRs),
        .IF_ID_RegisterRt  (IF_ID_RegisterRt),
        .IF_ID_UsesRt      (IF_ID_UsesRt),
        .IF_ID_Branch      (IF_ID_Branch),
        .branch_taken      (branch_taken),
        .jump              (jump),
        .PC_write          (PC_write),
        .IF_ID_write       (IF_ID_write),
        .ID_EX_bubble      (ID_EX_bubble),
        .IF_ID_flush       (IF_ID_flush)
`ifdef HAZARD_STATS_EN
        ,
        .stall_count       (stall_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit readsReg(input logic [4:0] r);
        return (r != 5'd0) && ((r == IF_ID_RegisterRs) || (IF_ID_UsesRt && (r == IF_ID_RegisterRt)));
    endfunction

    // Drives one cycle's inputs after the falling edge so they settle well before the next rising edge.
    task automatic applyStimulus(input bit r, input bit exLoad, input bit exWr, input logic [4:0] exRd,
                                 input bit memLoad, input logic [4:0] memRd,
                                 input logic [4:0] rs, input logic [4:0] rt, input bit usesRt,
                                 input bit br, input bit taken, input bit jmp);
        @(negedge clk);
        rst               = r;
        ID_EX_MemRead     = exLoad;
        ID_EX_RegWrite    = exWr;
        ID_EX_RegisterRd  = exRd;
        EX_MEM_MemRead    = memLoad;
        EX_MEM_RegisterRd = memRd;
        IF_ID_RegisterRs  = rs;
        IF_ID_RegisterRt  = rt;
        IF_ID_UsesRt      = usesRt;
        IF_ID_Branch      = br;
        branch_taken      = taken;
        jump              = jmp;
        #1;
    endtask

    // Works out what the current cycle should do, then advances the model past the next rising edge.
    task automatic evalModel();
        bit exHit;
        bit loadBranch;
        bit anyHazard;
        exHit      = readsReg(ID_EX_RegisterRd);
        loadBranch = IF_ID_Branch && ID_EX_MemRead && exHit;
        anyHazard  = (ID_EX_MemRead && exHit) ||
                     (IF_ID_Branch && ID_EX_RegWrite && exHit) ||
                     (IF_ID_Branch && EX_MEM_MemRead && readsReg(EX_MEM_RegisterRd));
        expStall   = !rst && ((holdLeft > 0) || anyHazard);
        if (rst) begin
            holdLeft   = 0;
            modelCount = 0;
            countKnown = 1;
        end else begin
            if (holdLeft > 0) holdLeft = holdLeft - 1;
            else if (loadBranch) holdLeft = 1;
            if (expStall && modelCount < 65535) modelCount = modelCount + 1;
        end
    endtask

    task automatic checkOutput(input string tag);
        bit expFlush;
        int countBefore;
        bit knownBefore;
        countBefore = modelCount;
        knownBefore = countKnown;
        evalModel();
        expFlush = !rst && !expStall && (jump || (IF_ID_Branch && branch_taken));
        assertCount++;
        assert (PC_write === !expStall) else begin
            failCount++;
            $error("[TB] FAIL %s PC_write observed=%b expected=%b", tag, PC_write, !expStall);
        end
        assertCount++;
        assert (IF_ID_write === !expStall) else begin
            failCount++;
            $error("[TB] FAIL %s IF_ID_write observed=%b expected=%b", tag, IF_ID_write, !expStall);
        end
        assertCount++;
        assert (ID_EX_bubble === expStall) else begin
            failCount++;
            $error("[TB] FAIL %s ID_EX_bubble observed=%b expected=%b", tag, ID_EX_bubble, expStall);
        end
        assertCount++;
        assert (IF_ID_flush === expFlush) else begin
            failCount++;
            $error("[TB] FAIL %s IF_ID_flush observed=%b expected=%b", tag, IF_ID_flush, expFlush);
        end
`ifdef HAZARD_STATS_EN
        if (knownBefore) begin
            assertCount++;
            assert (stall_count === 16'(countBefore)) else begin
                failCount++;
                $error("[TB] FAIL %s stall_count observed=%0d expected=%0d", tag, stall_count, countBefore);
            end
        end
`else
        if (knownBefore && countBefore < 0) $display("[TB] unreachable");
`endif
    endtask

    initial begin
        // Reset, with hazard-looking inputs that must be ignored.
        applyStimulus(1, 1, 1, 5'd5, 1, 5'd5, 5'd5, 5'd5, 1, 1, 1, 1); checkOutput("reset_forced");
        applyStimulus(1, 0, 0, 5'd0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0); checkOutput("reset_idle");

        // Load-use: lw $5 in EX, add $6,$5,$7 in ID, then the bubble clears EX.
        applyStimulus(0, 1, 1, 5'd5, 0, 5'd0, 5'd5, 5'd7, 1, 0, 0, 0); checkOutput("loaduse_stall");
        applyStimulus(0, 0, 0, 5'd0, 1, 5'd5, 5'd5, 5'd7, 1, 0, 0, 0); checkOutput("loaduse_release");

        // Branch after load: two stall cycles, then the taken branch flushes.
        applyStimulus(0, 1, 1, 5'd3, 0, 5'd0, 5'd3, 5'd4, 1, 1, 1, 0); checkOutput("ldbr_stall1");
        applyStimulus(0, 0, 0, 5'd0, 1, 5'd3, 5'd3, 5'd4, 1, 1, 1, 0); checkOutput("ldbr_stall2");
        applyStimulus(0, 0, 0, 5'd0, 0, 5'd0, 5'd3, 5'd4, 1, 1, 1, 0); checkOutput("ldbr_flush");

        // Branch after ALU op, then the same with $0 as destination.
        applyStimulus(0, 0, 1, 5'd8, 0, 5'd0, 5'd8, 5'd0, 1, 1, 0, 0); checkOutput("albr_stall");
        applyStimulus(0, 0, 0, 5'd0, 0, 5'd0, 5'd8, 5'd0, 1, 1, 0, 0); checkOutput("albr_release");
        applyStimulus(0, 0, 1, 5'd0, 0, 5'd0, 5'd0, 5'd0, 1, 1, 0, 0); checkOutput("albr_r0");

        // Jump alone flushes; jump during load-use is suppressed.
        applyStimulus(0, 0, 0, 5'd0, 0, 5'd0, 5'd1, 5'd2, 0, 0, 0, 1); checkOutput("jump_flush");
        applyStimulus(0, 1, 1, 5'd9, 0, 5'd0, 5'd9, 5'd2, 0, 0, 0, 1); checkOutput("jump_stalled");

        // Reset arriving in the HOLD cycle aborts the remaining stall.
        applyStimulus(0, 1, 1, 5'd3, 0, 5'd0, 5'd3, 5'd4, 1, 1, 0, 0); checkOutput("rsthold_enter");
        applyStimulus(1, 0, 0, 5'd0, 1, 5'd3, 5'd3, 5'd4, 1, 1, 0, 0); checkOutput("rsthold_reset");
        applyStimulus(0, 0, 0, 5'd0, 0, 5'd0, 5'd3, 5'd4, 1, 1, 0, 0); checkOutput("rsthold_run");

        // Random traffic over a small register set so matches are frequent.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 24) == 0), 1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
                          1'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom),
                          ($urandom_range(0, 3) == 0));
            checkOutput("random");
        end

`ifdef HAZARD_STATS_EN
        // Saturation: hold a load-use hazard long enough to overflow a 16-bit count.
        applyStimulus(1, 0, 0, 5'd0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0); checkOutput("sat_reset");
        for (int i = 0; i < 65535; i++) begin
            applyStimulus(0, 1, 1, 5'd2, 0, 5'd0, 5'd2, 5'd0, 0, 0, 0, 0);
            evalModel();
        end
        applyStimulus(0, 1, 1, 5'd2, 0, 5'd0, 5'd2, 5'd0, 0, 0, 0, 0); checkOutput("sat_full");
        applyStimulus(0, 0, 0, 5'd0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0); checkOutput("sat_hold");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
